// File: rtl/log_domain_fp16_mul.sv
// FP16 multiplier working in the log2 domain with host-loaded log2/exp2 LUTs, two-cycle latency.
// Defining LOG_MUL_DIV_EN adds the mul_or_div input and a log-domain divide mode.
module log_domain_fp16_mul #(
  parameter int unsigned FLOAT_LEN = 16,
  parameter int unsigned EXP_LEN   = 5,
  parameter int unsigned MANT_LEN  = 10,
  parameter int unsigned LUT_SIZE  = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
`ifdef LOG_MUL_DIV_EN
  input  logic                 mul_or_div,
`endif
  input  logic                 lut_wr_en,
  input  logic [MANT_LEN-1:0]  log2_lut_data_in,
  input  logic [FLOAT_LEN-1:0] exp2_lut_data_in,
  output logic [FLOAT_LEN-1:0] result
);

  localparam int unsigned IDX_W  = $clog2(LUT_SIZE);
  localparam int unsigned ESUM_W = EXP_LEN + 2;
  localparam int unsigned FRAC_W = MANT_LEN + 1;
  localparam logic [EXP_LEN-1:0] EXP_MAX = {EXP_LEN{1'b1}};
  localparam logic [EXP_LEN-1:0] BIAS    = {1'b0, {(EXP_LEN-1){1'b1}}};
  localparam logic [FLOAT_LEN-1:0] QNAN  = {1'b0, EXP_MAX, 1'b1, {(MANT_LEN-1){1'b0}}};

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  logic [MANT_LEN-1:0] r_log2_lut [LUT_SIZE];
  logic [MANT_LEN-1:0] r_exp2_lut [LUT_SIZE];
  logic [IDX_W-1:0]    r_wr_ptr;

  logic [EXP_LEN-1:0]  w_ea, w_eb;
  logic [MANT_LEN-1:0] w_ma, w_mb, w_log_a, w_log_b, w_frac;
  logic                w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [FRAC_W-1:0]   w_frac_sum;
  logic [ESUM_W-1:0]   w_exp;
  cls_t                w_cls;
  logic                w_ovf, w_unf, w_unused;
  logic [MANT_LEN-1:0] w_exp2;
  logic [FLOAT_LEN-1:0] w_result;
`ifdef LOG_MUL_DIV_EN
  logic [FRAC_W-1:0]   w_frac_diff;
`endif

  logic                r_sign;
  logic [IDX_W-1:0]    r_frac_idx;
  logic [ESUM_W-1:0]   r_exp;
  cls_t                r_cls;
  logic [FLOAT_LEN-1:0] r_result;

  // LUT storage is deliberately outside reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      r_log2_lut[r_wr_ptr] <= log2_lut_data_in;
      r_exp2_lut[r_wr_ptr] <= exp2_lut_data_in[MANT_LEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_wr_ptr <= '0;
    else if (lut_wr_en) r_wr_ptr <= r_wr_ptr + IDX_W'(1);
    else                r_wr_ptr <= '0;
  end

  assign w_ea     = a[FLOAT_LEN-2 -: EXP_LEN];
  assign w_eb     = b[FLOAT_LEN-2 -: EXP_LEN];
  assign w_ma     = a[MANT_LEN-1:0];
  assign w_mb     = b[MANT_LEN-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EXP_MAX) && (w_ma == '0);
  assign w_b_inf  = (w_eb == EXP_MAX) && (w_mb == '0);
  assign w_a_nan  = (w_ea == EXP_MAX) && (w_ma != '0);
  assign w_b_nan  = (w_eb == EXP_MAX) && (w_mb != '0);
  assign w_log_a  = r_log2_lut[w_ma[MANT_LEN-1 -: IDX_W]];
  assign w_log_b  = r_log2_lut[w_mb[MANT_LEN-1 -: IDX_W]];
  assign w_frac_sum = {1'b0, w_log_a} + {1'b0, w_log_b};
`ifdef LOG_MUL_DIV_EN
  assign w_frac_diff = {1'b0, w_log_a} - {1'b0, w_log_b};
`endif

  // Stage 1: log-domain add (or subtract), exponent combine and operand classification.
  always_comb begin
    w_frac = w_frac_sum[MANT_LEN-1:0];
    w_exp  = ESUM_W'(w_ea) + ESUM_W'(w_eb) - ESUM_W'(BIAS) + ESUM_W'(w_frac_sum[MANT_LEN]);
    w_cls  = CLS_NORM;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) w_cls = CLS_NAN;
    else if (w_a_inf || w_b_inf)                                               w_cls = CLS_INF;
    else if (w_a_zero || w_b_zero)                                             w_cls = CLS_ZERO;
`ifdef LOG_MUL_DIV_EN
    if (mul_or_div) begin
      w_frac = w_frac_diff[MANT_LEN-1:0];
      w_exp  = ESUM_W'(w_ea) - ESUM_W'(w_eb) + ESUM_W'(BIAS) - ESUM_W'(w_frac_diff[MANT_LEN]);
      w_cls  = CLS_NORM;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) w_cls = CLS_NAN;
      else if (w_a_inf || w_b_zero)                                              w_cls = CLS_INF;
      else if (w_a_zero || w_b_inf)                                              w_cls = CLS_ZERO;
    end
`endif
  end

  assign w_unused = &{1'b0, exp2_lut_data_in[FLOAT_LEN-1:MANT_LEN], w_frac[MANT_LEN-IDX_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign     <= 1'b0;
      r_frac_idx <= '0;
      r_exp      <= '0;
      r_cls      <= CLS_NORM;
    end else begin
      r_sign     <= a[FLOAT_LEN-1] ^ b[FLOAT_LEN-1];
      r_frac_idx <= w_frac[MANT_LEN-1 -: IDX_W];
      r_exp      <= w_exp;
      r_cls      <= w_cls;
    end
  end

  // Stage 2: exp2 lookup and special-case / range resolution.
  assign w_exp2 = r_exp2_lut[r_frac_idx];
  assign w_ovf  = !r_exp[ESUM_W-1] && (r_exp[ESUM_W-2:0] >= (ESUM_W-1)'(EXP_MAX));
  assign w_unf  = r_exp[ESUM_W-1] || (r_exp == '0);

  always_comb begin
    w_result = {r_sign, r_exp[EXP_LEN-1:0], w_exp2};
    case (r_cls)
      CLS_NAN:  w_result = QNAN;
      CLS_INF:  w_result = {r_sign, EXP_MAX, MANT_LEN'(0)};
      CLS_ZERO: w_result = {r_sign, (FLOAT_LEN-1)'(0)};
      default: begin
        if (w_ovf)      w_result = {r_sign, EXP_MAX, MANT_LEN'(0)};
        else if (w_unf) w_result = {r_sign, (FLOAT_LEN-1)'(0)};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_result <= '0;
    else        r_result <= w_result;
  end

  assign result = r_result;

endmodule

// File: tb/tb_log_domain_fp16_mul.sv
// Self-checking bench for log_domain_fp16_mul: directed table, latency/reset sequences, random stream.
module tb_log_domain_fp16_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        lut_wr_en = 1'b0;
  logic [9:0]  log2_lut_data_in = '0;
  logic [15:0] exp2_lut_data_in = '0;
  logic [15:0] result;

  int n_cmp = 0;
  int n_err = 0;

  log_domain_fp16_mul dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
`ifdef LOG_MUL_DIV_EN
    .mul_or_div(1'b0),
`endif
    .lut_wr_en(lut_wr_en), .log2_lut_data_in(log2_lut_data_in),
    .exp2_lut_data_in(exp2_lut_data_in), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic        approx;
  } vec_t;

  function automatic real fp2r(input logic [15:0] x);
    real v;
    if (x[14:10] == 5'd0) return 0.0;
    v = (1.0 + real'(x[9:0]) / 1024.0) * $pow(2.0, real'(int'(x[14:10])) - 15.0);
    return x[15] ? -v : v;
  endfunction

  // Spec-level classification: returns {is_exact, exact_value}; is_exact=0 means approximate product.
  function automatic logic [16:0] ref_special(input logic [15:0] x, input logic [15:0] y);
    logic s, xz, yz, xi, yi, xn, yn;
    s  = x[15] ^ y[15];
    xz = (x[14:10] == 0);  yz = (y[14:10] == 0);
    xi = (x[14:10] == 31) && (x[9:0] == 0);
    yi = (y[14:10] == 31) && (y[9:0] == 0);
    xn = (x[14:10] == 31) && (x[9:0] != 0);
    yn = (y[14:10] == 31) && (y[9:0] != 0);
    if (xn || yn || (xz && yi) || (xi && yz)) return {1'b1, 16'h7E00};
    if (xi || yi) return {1'b1, s, 15'h7C00};
    if (xz || yz) return {1'b1, s, 15'h0000};
    return {1'b0, 16'h0000};
  endfunction

  task automatic check_exact(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_approx(input string nm, input logic [15:0] act,
                              input logic [15:0] x, input logic [15:0] y);
    real p, r, d, ap;
    bit bad;
    p  = fp2r(x) * fp2r(y);
    r  = fp2r(act);
    d  = (r > p) ? r - p : p - r;
    ap = (p < 0.0) ? -p : p;
    bad = (act[15] !== (x[15] ^ y[15])) || (act[14:10] == 5'd31) || (act[14:10] == 5'd0) ||
          (d > 0.015 * ap);
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got %h (%f), expected %f within 1.5%% (a=%h b=%h)", nm, act, r, p, x, y);
    end
  endtask

  task automatic check_ref(input string nm, input logic [15:0] act,
                           input logic [15:0] x, input logic [15:0] y);
    logic [16:0] sp;
    sp = ref_special(x, y);
    if (sp[16]) check_exact(nm, act, sp[15:0]);
    else        check_approx(nm, act, x, y);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [4:0] e;
    if ($urandom_range(0, 7) == 0) e = 5'd0;
    else                           e = 5'($urandom_range(8, 17));
    return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
  endfunction

  vec_t        tbl [12];
  logic [15:0] sa [100];
  logic [15:0] sb [100];

  initial begin
    tbl[0]  = '{16'h4000, 16'h4200, 16'h4600, 1'b1};
    tbl[1]  = '{16'h0000, 16'h4500, 16'h0000, 1'b0};
    tbl[2]  = '{16'h8000, 16'h3C00, 16'h8000, 1'b0};
    tbl[3]  = '{16'hBE00, 16'h4000, 16'hC200, 1'b1};
    tbl[4]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 1'b0};
    tbl[5]  = '{16'h0400, 16'h0400, 16'h0000, 1'b0};
    tbl[6]  = '{16'h7C00, 16'h0000, 16'h7E00, 1'b0};
    tbl[7]  = '{16'hFE01, 16'h3C00, 16'h7E00, 1'b0};
    tbl[8]  = '{16'hFC00, 16'h3C00, 16'hFC00, 1'b0};
    tbl[9]  = '{16'h0200, 16'h4000, 16'h0000, 1'b0};
    tbl[10] = '{16'h8001, 16'h4000, 16'h8000, 1'b0};
    tbl[11] = '{16'h3C00, 16'h3C00, 16'h3C00, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_exact("reset_result", result, 16'h0000);
    rst_n = 1'b1;

    // Midpoint LUT burst, entry 0 first.
    lut_wr_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      log2_lut_data_in = 10'($rtoi($floor($ln(1.0 + (real'(i) + 0.5) / 128.0) / $ln(2.0) * 1024.0 + 0.5)));
      exp2_lut_data_in = 16'h3C00 |
                         16'($rtoi($floor(($pow(2.0, (real'(i) + 0.5) / 128.0) - 1.0) * 1024.0 + 0.5)));
      @(posedge clk);
      #1;
    end
    lut_wr_en = 1'b0;

    for (int i = 0; i < 12; i++) begin
      a = tbl[i].a;
      b = tbl[i].b;
      repeat (2) @(posedge clk);
      #1;
      if (tbl[i].approx) check_approx($sformatf("vec%0d", i), result, tbl[i].a, tbl[i].b);
      else               check_exact($sformatf("vec%0d", i), result, tbl[i].exp);
    end

    // Exact two-edge latency.
    a = 16'h0000; b = 16'h4500;
    repeat (2) @(posedge clk);
    #1;
    a = 16'h4000; b = 16'h4200;
    @(posedge clk);
    #1;
    check_exact("latency_edge1", result, 16'h0000);
    @(posedge clk);
    #1;
    check_approx("latency_edge2", result, 16'h4000, 16'h4200);

    // Random back-to-back stream.
    for (int i = 0; i < 100; i++) begin
      sa[i] = rnd_op();
      sb[i] = rnd_op();
    end
    for (int i = 0; i < 102; i++) begin
      if (i >= 2) check_ref($sformatf("stream%0d", i - 2), result, sa[i-2], sb[i-2]);
      if (i < 100) begin
        a = sa[i];
        b = sb[i];
      end
      @(posedge clk);
      #1;
    end

    // Mid-stream reset; LUT contents must survive.
    a = 16'h4000; b = 16'h4200;
    @(posedge clk);
    #1;
    a = 16'h3C00; b = 16'h4500;
    @(posedge clk);
    #1;
    check_approx("pre_reset", result, 16'h4000, 16'h4200);
    rst_n = 1'b0;
    #1;
    check_exact("rst_immediate", result, 16'h0000);
    @(posedge clk);
    #1;
    check_exact("rst_held", result, 16'h0000);
    rst_n = 1'b1;
    a = 16'hBE00; b = 16'h4000;
    @(posedge clk);
    #1;
    check_exact("rst_release_edge1", result, 16'h0000);
    @(posedge clk);
    #1;
    check_approx("rst_release_edge2", result, 16'hBE00, 16'h4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
